cfg_connection_block: RTL and testbench
=======================================

// Module: cfg_connection_block
// PURPOSE
//  Configurable connection block for the FPGA routing fabric. It selects CONTROLIN logic-block inputs from W routing tracks.
//  Each output has a binary-encoded track select and an optional inversion bit, replacing the flat one-hot c bus.
//  Configuration is loaded over a serial scan chain into a shadow register, then committed atomically to the active register.
//  cfg_out feeds the next block's cfg_in, so blocks daisy-chain across a tile.
// PARAMETERS
//  W          7  number of routing tracks
//  CONTROLIN  3  number of selected outputs (logic-block inputs)
//  SEL_W      cb_pkg::clog2(W+1)  select field width per output
//  REG_OUT    0  1 = register control_input (adds 1 cycle), 0 = combinational
//  FIELD_W    SEL_W+1 (localparam): per-output field = {inv, sel}
//  CFG_BITS   CONTROLIN*FIELD_W (localparam): scan chain length
// PORTS
//  clk            in   1         single clock, rising edge
//  reset          in   1         synchronous, active-high
//  tracks         in   W         routing track values (east/west shorted net)
//  cfg_en         in   1         shift one config bit this cycle
//  cfg_in         in   1         serial config data in
//  cfg_commit     in   1         copy shadow -> active this cycle
//  cfg_out        out  1         serial config data out (= shadow[0])
//  cfg_err        out  2         [0] range error, [1] short load; updated on commit
//  control_input  out  CONTROLIN selected track values
// BEHAVIOUR
//  Reset (sync, high): shadow, active, shift_cnt, cfg_err and the output register clear to 0.
//    Consequently cfg_out=0 and every output is disconnected (0).
//  Shift: when cfg_en=1, shadow <= {cfg_in, shadow[CFG_BITS-1:1]}.
//    The first bit shifted lands in bit 0 after CFG_BITS shifts.
//    Output i uses field shadow[i*FIELD_W +: FIELD_W]; sel = low SEL_W bits, inv = MSB.
//  shift_cnt counts cfg_en cycles since the last commit or reset, saturating at CFG_BITS.
//  Commit: when cfg_commit=1, active <= shadow (pre-shift value) and shift_cnt <= 0.
//    cfg_err[0] <= 1 if any committed sel > W, else 0.
//    cfg_err[1] <= (shift_cnt < CFG_BITS).
//    The active register is updated even when an error is flagged.
//  cfg_en and cfg_commit in the same cycle: commit captures the old shadow, the shift still occurs,
//    and shift_cnt <= 1 (that shift counts toward the next load).
//  Selection per output i:
//    sel==0 or sel>W -> 0, regardless of inv.
//    otherwise       -> tracks[sel-1] ^ inv.
//  REG_OUT=0: control_input follows tracks and active combinationally, with no X/Z on disconnected outputs.
//  REG_OUT=1: the same value is registered; latency is 1 cycle from tracks/active change.
//  cfg_out has no extra latency: it is the shadow[0] flop.
//  Reset mid-load or mid-commit: reset wins over every other action, and the next load must restart from bit 0.
//  cfg_err holds its value between commits.
// STRUCTURE
//  cb_pkg holds: constant function clog2; SEL_NONE = 0; the field-layout helper (FIELD_W computation).
//  Sub-module cb_cfg_chain #(CFG_BITS) contains the shadow shift register, active register and shift_cnt.
//    It outputs active, cfg_out and short_load.
//  Top level contains: the per-output decode/mux (generate loop), the range check, cfg_err and the optional output register.
// TESTING  (W=7, CONTROLIN=3, SEL_W=3, CFG_BITS=12 unless noted)
//  1. Reset asserted 2 cycles with tracks=7'h7F -> control_input=0, cfg_out=0, cfg_err=0.
//  2. Shift 12 bits so out0={0,3'd3}, out1={0,3'd7}, out2={0,3'd0}; commit.
//     tracks=7'b0000100 -> 3'b001; tracks=7'b1000000 -> 3'b010; cfg_err=0.
//  3. Load out2={1,3'd1} with the others unchanged, commit; tracks=0 -> control_input[2]=1.
//     Before the commit, control_input[2] keeps the old value while shifting (shadow isolation).
//  4. Instance W=5: out0 sel=6, commit -> cfg_err[0]=1, control_input[0]=0 for every tracks value.
//     Then a valid reload and commit -> cfg_err=0.
//  5. Only 5 shifts then commit -> cfg_err[1]=1 and active equals the partial shadow.
//     cfg_en and cfg_commit together -> the committed value is the pre-shift shadow.
//  6. Reset pulsed after 6 of 12 shifts -> shadow=0 and control_input=0.
//     A subsequent full 12-bit load behaves as in test 2.
//     Chain check: bit pattern 12'hA5C shifted in; cfg_out equals each bit 12 cycles later.
//  7. REG_OUT=1: a tracks toggle appears on control_input exactly 1 clk later; reset clears the register.

Source files
------------

// File: rtl/cb_pkg.sv
// Shared constants and helpers for the connection block: select width and field layout.
// Configuration fields are {inv, sel}; sel == SEL_NONE leaves the output disconnected.
package cb_pkg;

  localparam int SEL_NONE = 0;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int field_w(input int sel_w);
    return sel_w + 1;
  endfunction

endpackage

// File: rtl/cb_cfg_chain.sv
// Scan chain: serial shadow register, atomic commit into active, and a saturating load counter.
// Shift and commit take effect on the clock edge; no backpressure, the chain accepts one bit per cfg_en.
module cb_cfg_chain
  import cb_pkg::*;
#(
  parameter int CFG_BITS = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_en,
  input  logic                cfg_in,
  input  logic                cfg_commit,
  output logic [CFG_BITS-1:0] shadow,
  output logic [CFG_BITS-1:0] active,
  output logic                cfg_out,
  output logic                short_load
);

  localparam int CNT_W = clog2(CFG_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);

  logic [CNT_W-1:0] shift_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow    <= '0;
      active    <= '0;
      shift_cnt <= '0;
    end else begin
      if (cfg_en) begin
        shadow <= {cfg_in, shadow[CFG_BITS-1:1]};
      end
      if (cfg_commit) begin
        active <= shadow;
      end
      // A shift coinciding with a commit is the first bit of the next load.
      if (cfg_commit) begin
        shift_cnt <= cfg_en ? CNT_W'(1) : '0;
      end else if (cfg_en && (shift_cnt != CNT_FULL)) begin
        shift_cnt <= shift_cnt + 1'b1;
      end
    end
  end

  assign cfg_out    = shadow[0];
  assign short_load = (shift_cnt < CNT_FULL);

endmodule

// File: rtl/cfg_connection_block.sv
// Connection block: each output picks one routing track by binary select, optionally inverted.
// Latency 0 (REG_OUT=0) or 1 cycle (REG_OUT=1); no backpressure, config is a free-running scan chain.
module cfg_connection_block
  import cb_pkg::*;
#(
  parameter int W         = 7,
  parameter int CONTROLIN = 3,
  parameter int SEL_W     = clog2(W + 1),
  parameter int REG_OUT   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [W-1:0]         tracks,
  input  logic                 cfg_en,
  input  logic                 cfg_in,
  input  logic                 cfg_commit,
  output logic                 cfg_out,
  output logic [1:0]           cfg_err,
  output logic [CONTROLIN-1:0] control_input
);

  localparam int FIELD_W  = field_w(SEL_W);
  localparam int CFG_BITS = CONTROLIN * FIELD_W;

  logic [CFG_BITS-1:0]  shadow;
  logic [CFG_BITS-1:0]  active;
  logic                 short_load;
  logic [CONTROLIN-1:0] sel_val;
  logic [CONTROLIN-1:0] range_bad;

  cb_cfg_chain #(
    .CFG_BITS(CFG_BITS)
  ) u_chain (
    .clk       (clk),
    .reset     (reset),
    .cfg_en    (cfg_en),
    .cfg_in    (cfg_in),
    .cfg_commit(cfg_commit),
    .shadow    (shadow),
    .active    (active),
    .cfg_out   (cfg_out),
    .short_load(short_load)
  );

  for (genvar gi = 0; gi < CONTROLIN; gi++) begin : g_out
    logic [SEL_W-1:0] a_sel;
    logic             a_inv;
    logic [SEL_W-1:0] s_sel;
    logic             o_val;

    assign a_sel = active[gi*FIELD_W +: SEL_W];
    assign a_inv = active[gi*FIELD_W + SEL_W];
    assign s_sel = shadow[gi*FIELD_W +: SEL_W];

    // Only sel values 1..W reach a track; everything else drives a clean 0.
    always_comb begin
      o_val = 1'b0;
      for (int t = 0; t < W; t++) begin
        if ((int'(a_sel) != SEL_NONE) && (int'(a_sel) == t + 1)) begin
          o_val = tracks[t] ^ a_inv;
        end
      end
    end

    assign sel_val[gi]   = o_val;
    assign range_bad[gi] = (int'(s_sel) > W);
  end

  // Error flags describe the value being committed, so check the shadow.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_err <= 2'b00;
    end else if (cfg_commit) begin
      cfg_err <= {short_load, |range_bad};
    end
  end

  if (REG_OUT != 0) begin : g_reg
    always_ff @(posedge clk) begin
      if (reset) begin
        control_input <= '0;
      end else begin
        control_input <= sel_val;
      end
    end
  end else begin : g_comb
    assign control_input = sel_val;
  end

endmodule

// File: tb/tb_cfg_connection_block.sv
// Scoreboard bench for cfg_connection_block: W=7 combinational, W=5 combinational and W=7 registered instances share one scan chain stimulus.
module tb_cfg_connection_block;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] tracks = 7'h00;
  logic [4:0] tracks5;
  logic       cfg_en = 1'b0;
  logic       cfg_in = 1'b0;
  logic       cfg_commit = 1'b0;

  logic       cfg_out7, cfg_out5, cfg_outr;
  logic [1:0] err7, err5, errr;
  logic [2:0] ci7, ci5, cir;

  assign tracks5 = tracks[4:0];

  always #5 clk = ~clk;

  cfg_connection_block #(.W(7), .CONTROLIN(3), .REG_OUT(0)) dut7 (
    .clk(clk), .reset(reset), .tracks(tracks), .cfg_en(cfg_en), .cfg_in(cfg_in),
    .cfg_commit(cfg_commit), .cfg_out(cfg_out7), .cfg_err(err7), .control_input(ci7)
  );

  cfg_connection_block #(.W(5), .CONTROLIN(3), .REG_OUT(0)) dut5 (
    .clk(clk), .reset(reset), .tracks(tracks5), .cfg_en(cfg_en), .cfg_in(cfg_in),
    .cfg_commit(cfg_commit), .cfg_out(cfg_out5), .cfg_err(err5), .control_input(ci5)
  );

  cfg_connection_block #(.W(7), .CONTROLIN(3), .REG_OUT(1)) dutr (
    .clk(clk), .reset(reset), .tracks(tracks), .cfg_en(cfg_en), .cfg_in(cfg_in),
    .cfg_commit(cfg_commit), .cfg_out(cfg_outr), .cfg_err(errr), .control_input(cir)
  );

  int errors = 0;
  int checks = 0;

  // Reference model of the scan chain.
  logic [11:0] m_shadow = '0;
  logic [11:0] m_active = '0;
  int          m_cnt = 0;
  logic [1:0]  m_err7 = '0;
  logic [1:0]  m_err5 = '0;

  logic [2:0]  sb[$];
  logic        cq[$];

  function automatic logic [2:0] exp_ci(input logic [11:0] act, input logic [6:0] tr, input int w);
    logic [2:0] r;
    int s;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      s = int'(act[i*4 +: 3]);
      if (s != 0 && s <= w) r[i] = tr[s-1] ^ act[i*4+3];
    end
    return r;
  endfunction

  function automatic logic range_err(input logic [11:0] v, input int w);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 3; i++) if (int'(v[i*4 +: 3]) > w) r = 1'b1;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    cfg_en = 1'b1; cfg_in = b;
    tick();
    m_shadow = {b, m_shadow[11:1]};
    if (m_cnt < 12) m_cnt++;
    cfg_en = 1'b0; cfg_in = 1'b0;
  endtask

  task automatic load(input logic [11:0] v);
    for (int i = 0; i < 12; i++) shift_bit(v[i]);
  endtask

  task automatic commit(input logic en, input logic b);
    cfg_commit = 1'b1; cfg_en = en; cfg_in = b;
    tick();
    m_err7   = {(m_cnt < 12), range_err(m_shadow, 7)};
    m_err5   = {(m_cnt < 12), range_err(m_shadow, 5)};
    m_active = m_shadow;
    if (en) begin
      m_shadow = {b, m_shadow[11:1]};
      m_cnt = 1;
    end else begin
      m_cnt = 0;
    end
    cfg_commit = 1'b0; cfg_en = 1'b0; cfg_in = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
    m_shadow = '0; m_active = '0; m_cnt = 0; m_err7 = '0; m_err5 = '0;
  endtask

  task automatic test_reset();
    logic [2:0] e;
    tracks = 7'h7F;
    do_reset(2);
    sb.push_back(exp_ci(m_active, tracks, 7));
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (ci7 !== e) begin errors++; $display("FAIL reset_ci7: got %b want %b", ci7, e); end
    checks++; if (ci5 !== 3'b000) begin errors++; $display("FAIL reset_ci5: got %b want 000", ci5); end
    checks++; if (cir !== 3'b000) begin errors++; $display("FAIL reset_cir: got %b want 000", cir); end
    checks++; if (cfg_out7 !== m_shadow[0]) begin errors++; $display("FAIL reset_cfg_out: got %b want %b", cfg_out7, m_shadow[0]); end
    checks++; if (err7 !== m_err7) begin errors++; $display("FAIL reset_err: got %b want %b", err7, m_err7); end
  endtask

  task automatic test_basic(input string tag);
    logic [2:0] e;
    logic [6:0] pats [2];
    pats[0] = 7'b0000100;
    pats[1] = 7'b1000000;
    load(12'h073);
    commit(1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tracks = pats[i];
      sb.push_back(exp_ci(m_active, tracks, 7));
      @(negedge clk);
      e = sb.pop_front();
      checks++; if (ci7 !== e) begin errors++; $display("FAIL %s_sel%0d: got %b want %b", tag, i, ci7, e); end
      tick();
    end
    checks++; if (err7 !== m_err7) begin errors++; $display("FAIL %s_err7: got %b want %b", tag, err7, m_err7); end
    checks++; if (err5 !== m_err5) begin errors++; $display("FAIL %s_err5: got %b want %b", tag, err5, m_err5); end
  endtask

  task automatic test_shadow();
    logic [2:0] e;
    logic [11:0] v;
    v = 12'h973;
    tracks = 7'h00;
    for (int i = 0; i < 12; i++) begin
      shift_bit(v[i]);
      sb.push_back(exp_ci(m_active, tracks, 7));
      @(negedge clk);
      e = sb.pop_front();
      checks++; if (ci7 !== e) begin errors++; $display("FAIL shadow_iso%0d: got %b want %b", i, ci7, e); end
    end
    commit(1'b0, 1'b0);
    sb.push_back(exp_ci(m_active, tracks, 7));
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (ci7 !== e) begin errors++; $display("FAIL shadow_inv: got %b want %b", ci7, e); end
  endtask

  task automatic test_range();
    logic [2:0] e;
    load(12'h006);
    commit(1'b0, 1'b0);
    @(negedge clk);
    checks++; if (err5 !== m_err5) begin errors++; $display("FAIL range_err5: got %b want %b", err5, m_err5); end
    for (int t = 0; t < 32; t++) begin
      tracks = 7'(t);
      sb.push_back(exp_ci(m_active, tracks, 5));
      #1;
      e = sb.pop_front();
      checks++; if (ci5 !== e) begin errors++; $display("FAIL range_ci5_t%0d: got %b want %b", t, ci5, e); end
    end
    load(12'h123);
    commit(1'b0, 1'b0);
    tracks = 7'b0010101;
    sb.push_back(exp_ci(m_active, tracks, 5));
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (ci5 !== e) begin errors++; $display("FAIL range_reload_ci5: got %b want %b", ci5, e); end
    checks++; if (err5 !== m_err5) begin errors++; $display("FAIL range_reload_err5: got %b want %b", err5, m_err5); end
    checks++; if (err7 !== m_err7) begin errors++; $display("FAIL range_reload_err7: got %b want %b", err7, m_err7); end
  endtask

  task automatic check_ci_pats(input string tag);
    logic [2:0] e;
    logic [6:0] pats [4];
    pats[0] = 7'h55; pats[1] = 7'h2A; pats[2] = 7'h7F; pats[3] = 7'h00;
    for (int i = 0; i < 4; i++) begin
      tracks = pats[i];
      sb.push_back(exp_ci(m_active, tracks, 7));
      #1;
      e = sb.pop_front();
      checks++; if (ci7 !== e) begin errors++; $display("FAIL %s_p%0d: got %b want %b", tag, i, ci7, e); end
    end
    checks++; if (err7 !== m_err7) begin errors++; $display("FAIL %s_err7: got %b want %b", tag, err7, m_err7); end
  endtask

  task automatic test_short();
    logic [4:0] part;
    part = 5'b10110;
    for (int i = 0; i < 5; i++) shift_bit(part[i]);
    commit(1'b0, 1'b0);
    @(negedge clk);
    check_ci_pats("short");
    tick();
    commit(1'b1, 1'b1);
    @(negedge clk);
    check_ci_pats("same_cycle");
    for (int i = 0; i < 11; i++) shift_bit(i[0]);
    commit(1'b0, 1'b0);
    @(negedge clk);
    check_ci_pats("after_same_cycle");
  endtask

  task automatic test_reset_mid();
    logic [2:0] e;
    for (int i = 0; i < 6; i++) shift_bit(1'b1);
    do_reset(1);
    tracks = 7'h7F;
    sb.push_back(exp_ci(m_active, tracks, 7));
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (ci7 !== e) begin errors++; $display("FAIL midreset_ci7: got %b want %b", ci7, e); end
    checks++; if (cfg_out7 !== m_shadow[0]) begin errors++; $display("FAIL midreset_cfg_out: got %b want %b", cfg_out7, m_shadow[0]); end
    tick();
    test_basic("reload");
  endtask

  task automatic test_chain();
    logic [23:0] p;
    logic e;
    p = {12'h3C9, 12'hA5C};
    for (int i = 0; i < 24; i++) begin
      shift_bit(p[i]);
      cq.push_back(p[i]);
      if (cq.size() == 12) begin
        e = cq.pop_front();
        @(negedge clk);
        checks++; if (cfg_out7 !== e) begin errors++; $display("FAIL chain_bit%0d: got %b want %b", i - 11, cfg_out7, e); end
      end
    end
  endtask

  task automatic test_regout();
    logic [2:0] e;
    logic [2:0] sr[$];
    tracks = 7'h00;
    tick();
    sr.push_back(exp_ci(m_active, tracks, 7));
    for (int i = 0; i < 8; i++) begin
      tracks = (i % 2 == 0) ? 7'b1000100 : 7'($urandom_range(0, 127));
      sr.push_back(exp_ci(m_active, tracks, 7));
      @(negedge clk);
      e = sr.pop_front();
      checks++; if (cir !== e) begin errors++; $display("FAIL regout_lat%0d: got %b want %b", i, cir, e); end
      e = exp_ci(m_active, tracks, 7);
      checks++; if (ci7 !== e) begin errors++; $display("FAIL regout_comb%0d: got %b want %b", i, ci7, e); end
      tick();
    end
    e = sr.pop_front();
    checks++; if (cir !== e) begin errors++; $display("FAIL regout_last: got %b want %b", cir, e); end
    reset = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (cir !== 3'b000) begin errors++; $display("FAIL regout_reset: got %b want 000", cir); end
    reset = 1'b0;
    m_shadow = '0; m_active = '0; m_cnt = 0; m_err7 = '0; m_err5 = '0;
  endtask

  initial begin
    test_reset();
    tick();
    test_basic("basic");
    test_shadow();
    tick();
    test_range();
    tick();
    test_short();
    tick();
    test_reset_mid();
    test_chain();
    tick();
    test_regout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
